// File: rtl/uart_word_sender.sv
// uart_word_sender: queues words in a small FIFO and hands them to the UART
// transmitter one byte at a time, least-significant byte first.
module uart_word_sender #(
    parameter int unsigned NB_WORD    = 32,
    parameter int unsigned N_DATA     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_WORD-1:0] i_word_in,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    output logic               o_overflow,
    output logic               o_tx_busy,
    output logic               o_tx_start,
    output logic [N_DATA-1:0]  o_tx_data,
    input  logic               i_read_tx,
    input  logic               i_tx_done_tick
);

    localparam int unsigned N_BYTES = NB_WORD / N_DATA;
    localparam int unsigned CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(N_BYTES - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitBusy,
        StWaitDone
    } state_t;

    logic [NB_WORD-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FCNT_W-1:0]  r_count;
    logic               r_overflow;

    state_t             r_state;
    logic [NB_WORD-1:0] r_shift;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic               r_tx_start;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign w_push  = i_word_valid && !w_full;
    assign w_pop   = (r_state == StIdle) && !w_empty;

    assign o_word_ready = !w_full;
    assign o_overflow   = r_overflow;
    assign o_tx_busy    = !w_empty || (r_state != StIdle);
    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_shift[N_DATA-1:0];

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_word_in;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + FCNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - FCNT_W'(1);
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (i_word_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Byte sequencer: request, wait for the done level to drop, then to return.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_tx_start <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_byte_cnt <= '0;
                        r_tx_start <= 1'b1;
                        r_state    <= StReq;
                    end
                end
                StReq: begin
                    if (i_read_tx) begin
                        r_tx_start <= 1'b0;
                        r_state    <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    // Skip the done level still high from the transmitter's idle state.
                    if (!i_tx_done_tick) begin
                        r_state <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (i_tx_done_tick) begin
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_state <= StIdle;
                        end else begin
                            r_shift    <= r_shift >> N_DATA;
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                            r_tx_start <= 1'b1;
                            r_state    <= StReq;
                        end
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_sender.sv
// Testbench for uart_word_sender: a behavioural transmitter pops expected
// bytes from a scoreboard as the DUT requests them.
module tb_uart_word_sender;

    localparam int NB_WORD    = 32;
    localparam int N_DATA     = 8;
    localparam int FIFO_DEPTH = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [NB_WORD-1:0] word_in;
    logic               word_valid;
    logic               word_ready;
    logic               overflow;
    logic               tx_busy;
    logic               tx_start;
    logic [N_DATA-1:0]  tx_data;
    logic               read_tx;
    logic               tx_done_tick;

    uart_word_sender #(
        .NB_WORD   (NB_WORD),
        .N_DATA    (N_DATA),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_word_in     (word_in),
        .i_word_valid  (word_valid),
        .o_word_ready  (word_ready),
        .o_overflow    (overflow),
        .o_tx_busy     (tx_busy),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_read_tx     (read_tx),
        .i_tx_done_tick(tx_done_tick)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   words_done = 0;
    int   bytes_done = 0;
    bit   tx_enable  = 1'b0;
    int   ack_delay  = 0;
    int   done_hold  = 0;
    int   frame_len  = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural transmitter and monitor.
    initial begin : xmtr
        exp_t e;
        bit   have;
        read_tx      = 1'b0;
        tx_done_tick = 1'b1;
        forever begin
            @(negedge clock);
            if (tx_enable && tx_start) begin
                have = (sb.size() > 0);
                check("req_expected", {31'd0, have}, 32'd1);
                if (have) e = sb.pop_front();
                else e = '0;
                for (int i = 0; i < ack_delay; i++) begin
                    check("req_hold", {31'd0, tx_start}, 32'd1);
                    check("req_data_hold", {24'd0, tx_data}, {24'd0, e.data});
                    @(negedge clock);
                end
                check("tx_byte", {24'd0, tx_data}, {24'd0, e.data});
                read_tx = 1'b1;
                @(negedge clock);
                read_tx = 1'b0;
                check("start_drop", {31'd0, tx_start}, 32'd0);
                for (int i = 0; i < done_hold; i++) begin
                    @(negedge clock);
                    check("no_req_done_high", {31'd0, tx_start}, 32'd0);
                end
                tx_done_tick = 1'b0;
                for (int i = 0; i < frame_len; i++) begin
                    @(negedge clock);
                    check("no_req_done_low", {31'd0, tx_start}, 32'd0);
                end
                tx_done_tick = 1'b1;
                bytes_done++;
                if (e.last) words_done++;
            end
        end
    end

    task automatic push(input logic [31:0] w, input bit ok);
        @(negedge clock);
        check("word_ready_pre_push", {31'd0, word_ready}, {31'd0, ok});
        word_valid = 1'b1;
        word_in    = w;
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                exp_t e;
                e.data = w[8*b +: 8];
                e.last = (b == 3);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drop_valid();
        @(negedge clock);
        word_valid = 1'b0;
    endtask

    task automatic wait_words(input int target, input string name);
        int deadline;
        deadline = cyc + 3000;
        wait (words_done >= target || cyc >= deadline);
        check(name, {31'd0, words_done >= target}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        word_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_tx_busy"}, {31'd0, tx_busy}, 32'd0);
        check({tag, "_word_ready"}, {31'd0, word_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        int base;
        int deadline;
        reset      = 1'b1;
        word_valid = 1'b0;
        word_in    = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("por");

        // Single word: request latency and busy fall.
        tx_enable = 1'b1;
        base = words_done;
        push(32'hA1B2C3D4, 1'b1);
        drop_valid();
        check("start_lat_edge1", {31'd0, tx_start}, 32'd0);
        @(negedge clock);
        check("start_lat_edge2", {31'd0, tx_start}, 32'd1);
        check("first_byte_d4", {24'd0, tx_data}, 32'hD4);
        wait_words(base + 1, "word1_done");
        check("busy_before_idle", {31'd0, tx_busy}, 32'd1);
        @(negedge clock);
        check("busy_fall", {31'd0, tx_busy}, 32'd0);
        check("sb_empty_1", sb.size(), 32'd0);

        // Delayed acknowledge and done-level filtering.
        ack_delay = 10;
        done_hold = 3;
        base = words_done;
        push(32'h11223344, 1'b1);
        drop_valid();
        wait_words(base + 1, "delayed_ack_done");
        ack_delay = 0;
        done_hold = 0;

        // Push coinciding with pop at count 1.
        base = words_done;
        push(32'hCAFEF00D, 1'b1);
        push(32'h0BADBEEF, 1'b1);
        drop_valid();
        wait_words(base + 2, "push_pop_words_done");
        check("sb_empty_2", sb.size(), 32'd0);

        // Fill with transmitter stalled: one word held by the sequencer, four queued.
        do_reset();
        tx_enable = 1'b0;
        push(32'h00000000, 1'b1);
        drop_valid();
        @(negedge clock);
        check("held_req", {31'd0, tx_start}, 32'd1);
        push(32'h10000001, 1'b1);
        push(32'h20000002, 1'b1);
        push(32'h30000003, 1'b1);
        push(32'h40000004, 1'b1);
        push(32'h50000005, 1'b0);
        drop_valid();
        check("ovf_after_drop", {31'd0, overflow}, 32'd1);
        check("full_not_ready", {31'd0, word_ready}, 32'd0);

        // Push while full on the same edge as a pop: dropped, overflow set.
        do_reset();
        check("ovf_cleared_by_reset", {31'd0, overflow}, 32'd0);
        tx_enable = 1'b0;
        push(32'hF0E1D2C3, 1'b1);
        drop_valid();
        @(negedge clock);
        push(32'h04030201, 1'b1);
        push(32'h08070605, 1'b1);
        push(32'h0C0B0A09, 1'b1);
        push(32'h100F0E0D, 1'b1);
        drop_valid();
        check("full_ovf_clear", {31'd0, overflow}, 32'd0);
        base = words_done;
        tx_enable = 1'b1;
        wait_words(base + 1, "first_of_full_done");
        @(negedge clock);
        check("full_in_idle", {31'd0, word_ready}, 32'd0);
        word_valid = 1'b1;
        word_in    = 32'hDEADDEAD;
        @(negedge clock);
        word_valid = 1'b0;
        check("ovf_on_pop_edge", {31'd0, overflow}, 32'd1);
        check("ready_after_pop", {31'd0, word_ready}, 32'd1);
        wait_words(base + 5, "full_drain_done");
        check("sb_empty_3", sb.size(), 32'd0);

        // Reset in the middle of a word with two words queued.
        do_reset();
        tx_enable = 1'b1;
        base = bytes_done;
        push(32'h44332211, 1'b1);
        push(32'h88776655, 1'b1);
        push(32'hCCBBAA99, 1'b1);
        drop_valid();
        deadline = cyc + 3000;
        wait (bytes_done >= base + 2 || cyc >= deadline);
        check("two_bytes_sent", {31'd0, bytes_done >= base + 2}, 32'd1);
        tx_enable = 1'b0;
        do_reset();
        check_reset_outputs("midword");
        tx_enable = 1'b1;
        base = words_done;
        push(32'h13579BDF, 1'b1);
        drop_valid();
        wait_words(base + 1, "post_reset_word_done");
        repeat (2) @(negedge clock);
        check("post_reset_no_extra", {31'd0, tx_busy}, 32'd0);
        check("sb_empty_4", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
